// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// The FSM state is gray-encoded so that bit 1 alone reads as "debounced level is high".
package debounce_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_RISE_WAIT = 2'b01,
        ST_HIGH      = 2'b11,
        ST_FALL_WAIT = 2'b10
    } state_t;

    // Debounced level implied by a state: high while settled high or qualifying a fall.
    function automatic logic state_is_high(input state_t s);
        return (s == ST_HIGH) || (s == ST_FALL_WAIT);
    endfunction

endpackage

// File: rtl/multi_stage_synchronizer.sv
// Flip-flop chain that brings an asynchronous level into the i_clk domain.
// The chain is tagged ASYNC_REG so implementation keeps the stages packed together.
module multi_stage_synchronizer #(
    parameter int par_stages = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [par_stages-1:0] sync_q;

    // Shift the raw level through the chain, oldest sample at the top bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[par_stages-2:0], i_d};
        end
    end

    assign o_q = sync_q[par_stages-1];

endmodule

// File: rtl/switch_debounce_pulse.sv
// Switch debouncer: synchronizes a raw bouncing level, accepts a new level only after it
// has held for par_T_debounce_val clocks, and emits a one-clock o_rise on each accepted
// 0->1 transition. Defining DEBOUNCE_FALL_PULSE_EN adds the o_fall port and its register,
// pulsing on each accepted 1->0 transition.
//
//   state        | meaning
//   -------------+----------------------------------------------------------
//   ST_LOW       | settled low, waiting for the synchronized input to go high
//   ST_RISE_WAIT | input high, timing how long it stays high before accepting
//   ST_HIGH      | settled high, waiting for the synchronized input to go low
//   ST_FALL_WAIT | input low, timing how long it stays low before accepting
module switch_debounce_pulse
    import debounce_pkg::*;
#(
    parameter int par_sync_stages     = 2,
    parameter int par_T_debounce_bits = 20,
    parameter int par_T_debounce_val  = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_x,
    output logic o_level,
`ifdef DEBOUNCE_FALL_PULSE_EN
    output logic o_rise,
    output logic o_fall
`else
    output logic o_rise
`endif
);

    // Last timer value of a qualifying wait; the timer parks here instead of wrapping.
    localparam logic [par_T_debounce_bits-1:0] TIMER_TC =
        par_T_debounce_bits'(par_T_debounce_val - 1);

    if (par_sync_stages < SYNC_STAGES_MIN || par_sync_stages > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("par_sync_stages out of range 2..4");
    end
    if (par_T_debounce_val < 2) begin : g_bad_val
        $error("par_T_debounce_val must be at least 2");
    end
    if ((64'd1 << par_T_debounce_bits) < 64'(par_T_debounce_val)) begin : g_bad_bits
        $error("par_T_debounce_bits too narrow for par_T_debounce_val");
    end

    logic                           s_sync;
    state_t                         state_q, state_d;
    logic [par_T_debounce_bits-1:0] timer_q, timer_d;
    logic                           level_q;
    logic                           rise_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
    logic                           fall_q;
`endif

    multi_stage_synchronizer #(
        .par_stages (par_sync_stages)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_x),
        .o_q     (s_sync)
    );

    // Next state and timer: an opposing sample always aborts a wait before the timer is consulted.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_LOW: begin
                if (s_sync) state_d = ST_RISE_WAIT;
            end
            ST_RISE_WAIT: begin
                if (!s_sync)                  state_d = ST_LOW;
                else if (timer_q == TIMER_TC) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (!s_sync) state_d = ST_FALL_WAIT;
            end
            ST_FALL_WAIT: begin
                if (s_sync)                   state_d = ST_HIGH;
                else if (timer_q == TIMER_TC) state_d = ST_LOW;
            end
            default: state_d = ST_LOW;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != TIMER_TC) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // State, timer and registered outputs; pulses are decoded from the transition being taken
    // so they line up with the level change on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_LOW;
            timer_q <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            level_q <= state_is_high(state_d);
            rise_q  <= (state_q == ST_RISE_WAIT) && (state_d == ST_HIGH);
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_q  <= (state_q == ST_FALL_WAIT) && (state_d == ST_LOW);
`endif
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
    assign o_fall  = fall_q;
`endif

endmodule
